shot_sequencer: RTL and testbench

- Game controller for the 4x4 grid of cell instances.
- Owns the per-cell row/column enables, fire strobe and load bus.
- Sequences board initialisation, accepts debounced row/column selections and fire presses, issues one fire transaction per press, then counts shots and detects win/lose from the grid's 32-bit display state.
- Sits between the switch/button input logic and the cell array; the video path is untouched.

---
 rtl/shot_sequencer_pkg.sv | 20 ++
 rtl/shot_sequencer_edge_rise.sv | 21 ++
 rtl/shot_sequencer.sv | 137 +++++++++++++
 tb/tb_shot_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/shot_sequencer_pkg.sv
// shot_sequencer_pkg: shared cell codes, game status codes, FSM states and helpers
package shot_pkg;

    localparam logic [1:0] WATER = 2'b00;
    localparam logic [1:0] SHIP  = 2'b01;
    localparam logic [1:0] MISS  = 2'b10;
    localparam logic [1:0] HIT   = 2'b11;

    localparam logic [1:0] GS_PLAY = 2'b00;
    localparam logic [1:0] GS_WIN  = 2'b01;
    localparam logic [1:0] GS_LOSE = 2'b10;
    localparam logic [1:0] GS_INIT = 2'b11;

    typedef enum logic [2:0] {INIT, IDLE, FIRE, SETTLE, CHECK, WIN, LOSE} state_e;

    function automatic logic [3:0] onehot2(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/shot_sequencer_edge_rise.sv
// edge_rise: registered one-bit rising-edge detector; history resets high so a held level never fires
module edge_rise (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o
);
    logic prev_q;
    logic rise_q;
    // remember last level and flag a 0->1 transition one cycle later
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_q <= 1'b1;
            rise_q <= 1'b0;
        end else begin
            prev_q <= d_i;
            rise_q <= d_i & ~prev_q;
        end
    end
    assign rise_o = rise_q;
endmodule

// File: rtl/shot_sequencer.sv
// shot_sequencer: loads the board, turns fire presses into row/column fire strobes, tracks win/lose
module shot_sequencer
    import shot_pkg::*;
#(
    parameter logic [31:0] BOARD_INIT = 32'h0041_1400,
    parameter int          MAX_SHOTS  = 12,
    parameter int          SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fire_btn,
    input  logic [3:0]  sel,
    input  logic        sel_error,
    input  logic        sel_is_col,
    input  logic        new_game,
    input  logic [31:0] cell_state,
    output logic [3:0]  row_en,
    output logic [3:0]  col_en,
    output logic        fire,
    output logic        load_we,
    output logic [1:0]  load_val,
    output logic [5:0]  shot_count,
    output logic [1:0]  game_state
);
    state_e      state_q, state_d;
    logic [3:0]  k_q, k_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  sel_q, sel_d;
    logic        col_q, col_d;
    logic [3:0]  row_en_q, row_en_d;
    logic [3:0]  col_en_q, col_en_d;
    logic        fire_q, fire_d;
    logic        load_we_q, load_we_d;
    logic [1:0]  load_val_q, load_val_d;
    logic [5:0]  shot_q, shot_d;
    logic [1:0]  gs_q, gs_d;
    logic        fire_rise;
    logic        ng_rise;
    logic        ship_left;

    edge_rise u_fire_edge (.clk(clk), .reset(reset), .d_i(fire_btn), .rise_o(fire_rise));
    edge_rise u_ng_edge   (.clk(clk), .reset(reset), .d_i(new_game), .rise_o(ng_rise));

    // any cell still holding an unhit ship keeps the game alive
    always_comb begin
        ship_left = 1'b0;
        for (int i = 0; i < 16; i++) ship_left = ship_left | (cell_state[2*i +: 2] == SHIP);
    end

    // state and registered outputs; outputs follow the state one cycle later
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= INIT;
            k_q        <= '0;
            cnt_q      <= '0;
            sel_q      <= '0;
            col_q      <= 1'b0;
            row_en_q   <= '0;
            col_en_q   <= '0;
            fire_q     <= 1'b0;
            load_we_q  <= 1'b0;
            load_val_q <= '0;
            shot_q     <= '0;
            gs_q       <= GS_INIT;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            col_q      <= col_d;
            row_en_q   <= row_en_d;
            col_en_q   <= col_en_d;
            fire_q     <= fire_d;
            load_we_q  <= load_we_d;
            load_val_q <= load_val_d;
            shot_q     <= shot_d;
            gs_q       <= gs_d;
        end
    end

    // next state: board walk, press capture, settle timer, win/lose decision
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        col_d   = col_q;
        case (state_q)
            INIT: begin
                k_d = k_q + 4'd1;
                if (k_q == 4'd15) state_d = IDLE;
            end
            IDLE: begin
                if (fire_rise && !sel_error) begin
                    state_d = FIRE;
                    sel_d   = sel;
                    col_d   = sel_is_col;
                end
            end
            FIRE: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
            SETTLE: begin
                if (cnt_q == 4'(SETTLE_CYC - 1)) state_d = CHECK;
                else cnt_d = cnt_q + 4'd1;
            end
            CHECK: state_d = !ship_left ? WIN : (shot_q >= 6'(MAX_SHOTS)) ? LOSE : IDLE;
            WIN, LOSE: begin
                if (ng_rise) begin
                    state_d = INIT;
                    k_d     = '0;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // output decode: loads in INIT, one strobe in FIRE, status from state
    always_comb begin
        row_en_d   = (state_q == INIT) ? onehot2(k_q[3:2]) : (state_q == FIRE && !col_q) ? sel_q : 4'b0;
        col_en_d   = (state_q == INIT) ? onehot2(k_q[1:0]) : (state_q == FIRE && col_q) ? sel_q : 4'b0;
        fire_d     = state_q == FIRE;
        load_we_d  = state_q == INIT;
        load_val_d = (state_q == INIT) ? BOARD_INIT[{k_q, 1'b0} +: 2] : 2'b00;
        shot_d     = (state_q == INIT) ? 6'd0 : (state_q == FIRE && shot_q != 6'd63) ? shot_q + 6'd1 : shot_q;
        gs_d       = (state_q == INIT) ? GS_INIT : (state_q == WIN) ? GS_WIN : (state_q == LOSE) ? GS_LOSE : GS_PLAY;
    end

    assign row_en     = row_en_q;
    assign col_en     = col_en_q;
    assign fire       = fire_q;
    assign load_we    = load_we_q;
    assign load_val   = load_val_q;
    assign shot_count = shot_q;
    assign game_state = gs_q;
endmodule

// File: tb/tb_shot_sequencer.sv
// tb_shot_sequencer: transaction-level model of the game checked against shot_sequencer
module tb_shot_sequencer;
    localparam logic [31:0] BI = 32'h0041_1400;
    localparam int          MS = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fire_btn = 1'b0;
    logic [3:0]  sel = 4'b0;
    logic        sel_error = 1'b0;
    logic        sel_is_col = 1'b0;
    logic        new_game = 1'b0;
    logic [31:0] cell_state;
    logic [3:0]  row_en, col_en;
    logic        fire, load_we;
    logic [1:0]  load_val;
    logic [5:0]  shot_count;
    logic [1:0]  game_state;

    logic [1:0]  cells [16];
    logic [31:0] board = BI;
    int          shots = 0;
    int          status = 0;
    int          checks = 0;
    int          errors = 0;

    shot_sequencer dut (
        .clk(clk), .reset(reset), .fire_btn(fire_btn), .sel(sel), .sel_error(sel_error),
        .sel_is_col(sel_is_col), .new_game(new_game), .cell_state(cell_state),
        .row_en(row_en), .col_en(col_en), .fire(fire), .load_we(load_we), .load_val(load_val),
        .shot_count(shot_count), .game_state(game_state)
    );

    always #5 clk = ~clk;

    always_comb begin
        cell_state = '0;
        for (int i = 0; i < 16; i++) cell_state[2*i +: 2] = cells[i];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ships_left();
        int n = 0;
        for (int i = 0; i < 16; i++) if (cells[i] == 2'b01) n++;
        return n;
    endfunction

    // watch the board load; stop_at >= 0 returns right after that load index is seen
    task automatic init_seq(input int stop_at);
        int n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (load_we) begin
                if (n < 16) begin
                    check("init_row", row_en, 32'(4'b1 << (n / 4)));
                    check("init_col", col_en, 32'(4'b1 << (n % 4)));
                    check("init_val", load_val, board[2*n +: 2]);
                    check("init_gs", game_state, 3);
                    check("init_fire", fire, 0);
                    if (n == 5) check("cell5", load_val, 2'b01);
                    cells[n] = load_val;
                end
                if (n == stop_at) return;
                n++;
            end else if (n > 0) break;
        end
        check("init_loads", n, 16);
        check("idle_gs", game_state, 0);
        check("idle_shots", shot_count, 0);
        check("idle_outs", {row_en, col_en, fire, load_we}, 0);
        shots = 0;
        status = 0;
    endtask

    task automatic reset_low_check();
        reset = 1'b0;
        @(negedge clk);
        check("rst_outs", {row_en, col_en, fire, load_we, load_val, shot_count}, 0);
        check("rst_gs", game_state, 3);
        reset = 1'b1;
    endtask

    task automatic press(input logic [3:0] s, input bit c, input bit e, input int hold);
        bit live = (status == 0) && !e;
        int fires = 0;
        int first = 0;
        sel = s;
        sel_is_col = c;
        sel_error = e;
        fire_btn = 1'b1;
        for (int i = 1; i <= hold + 10; i++) begin
            @(negedge clk);
            if (i == 2) begin
                sel = 4'($urandom);
                sel_error = 1'($urandom);
                sel_is_col = 1'($urandom);
            end
            if (fire) begin
                fires++;
                if (first == 0) first = i;
                check("fire_row", row_en, c ? 0 : 32'(s));
                check("fire_col", col_en, c ? 32'(s) : 0);
                for (int k = 0; k < 16; k++)
                    if (c ? s[k % 4] : s[k / 4])
                        cells[k] = (cells[k] == 2'b01) ? 2'b11 : (cells[k] == 2'b00) ? 2'b10 : cells[k];
            end
            if (i == hold) fire_btn = 1'b0;
        end
        if (live) begin
            shots = (shots == 63) ? 63 : shots + 1;
            status = (ships_left() == 0) ? 1 : (shots >= MS) ? 2 : 0;
        end
        check("fire_count", fires, 32'(live));
        if (live) check("fire_lat", first, 3);
        check("shot_count", shot_count, shots);
        check("game_state", game_state, status);
    endtask

    task automatic restart();
        new_game = 1'b1;
        init_seq(-1);
        new_game = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int first;
        int fires;
        for (int i = 0; i < 16; i++) cells[i] = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_outs", {row_en, col_en, fire, load_we, load_val, shot_count}, 0);
        check("rst_gs", game_state, 3);
        reset = 1'b1;
        init_seq(-1);

        // quick win on shot 3 with a dropped bad selection in between
        press(4'b0010, 0, 0, 100);
        press(4'b0110, 0, 1, 2);
        press(4'b0001, 1, 0, 1);
        press(4'b0100, 0, 0, 3);
        check("win", game_state, 1);
        press(4'b0001, 0, 0, 2);
        restart();

        // twelve misses lose
        for (int j = 0; j < MS; j++) press(4'b0001, 0, 0, 1);
        check("lose", game_state, 2);
        restart();

        // last ship sunk on the final allowed shot wins
        press(4'b0010, 0, 0, 1);
        press(4'b0001, 1, 0, 1);
        for (int j = 0; j < 9; j++) press(4'b0001, 0, 0, 1);
        press(4'b1000, 1, 0, 1);
        check("win_prio", game_state, 1);
        restart();

        // reset during SETTLE with the button still held
        sel = 4'b0001;
        sel_is_col = 1'b0;
        sel_error = 1'b0;
        fire_btn = 1'b1;
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (fire) begin
                first = i;
                break;
            end
        end
        check("settle_fire", first, 3);
        reset_low_check();
        init_seq(-1);
        fires = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (fire) fires++;
        end
        check("held_no_fire", fires, 0);
        fire_btn = 1'b0;
        @(negedge clk);

        // reset in the middle of the board load
        reset_low_check();
        init_seq(7);
        reset_low_check();
        init_seq(-1);

        // random games
        for (int g = 0; g < 4; g++) begin
            for (int p = 0; p < 40 && status == 0; p++) begin
                bit e = ($urandom % 5) == 0;
                logic [3:0] s = e ? 4'(4'b0011 << ($urandom % 3)) : 4'(4'b0001 << ($urandom % 4));
                press(s, 1'($urandom), e, 1 + int'($urandom % 4));
            end
            if (status != 0) restart();
            else begin
                reset_low_check();
                init_seq(-1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
